// File: rtl/stack.sv
// Circular register-file LIFO with a downward-growing top index.
// Define STACK_STATUS_EN to add the count/empty/full occupancy outputs.
module stack #(
  parameter int StackDepth      = 4,
  parameter int DataWidth       = 32,
  parameter int StackDepthWidth = $clog2(StackDepth)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DataWidth-1:0]       data_in,
  output logic [DataWidth-1:0]       data_out,
`ifdef STACK_STATUS_EN
  output logic [StackDepthWidth:0]   count,
  output logic                       empty,
  output logic                       full,
`endif
  output logic [StackDepthWidth-1:0] index_out
);

  localparam logic [StackDepthWidth-1:0] TopIdx =
    StackDepthWidth'(StackDepth - 1);

  logic [DataWidth-1:0]       mem [StackDepth];
  logic [StackDepthWidth-1:0] index;
  logic [StackDepthWidth-1:0] index_dn;
  logic [StackDepthWidth-1:0] index_up;

  assign index_dn  = index - 1'b1;
  assign index_up  = index + 1'b1;
  assign data_out  = mem[index];
  assign index_out = index;

  always_ff @(posedge clk) begin
    if (!reset) begin
      index <= TopIdx;
      for (int i = 0; i < StackDepth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case ({push, pop})
        2'b10: begin
          index         <= index_dn;
          mem[index_dn] <= data_in;
        end
        2'b01: index <= index_up;
        // Simultaneous push and pop replaces the top in place.
        2'b11: mem[index] <= data_in;
        default: ;
      endcase
    end
  end

`ifdef STACK_STATUS_EN
  localparam logic [StackDepthWidth:0] FullCnt =
    (StackDepthWidth + 1)'(StackDepth);

  logic [StackDepthWidth:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: if (cnt_q != FullCnt) cnt_q <= cnt_q + 1'b1;
        2'b01: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FullCnt);
`endif

endmodule

// File: tb/tb_stack.sv
// Self-checking bench for stack (StackDepth=4, DataWidth=8).
// Status outputs are checked when STACK_STATUS_EN is defined.
module tb_stack;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic [1:0] index_out;
`ifdef STACK_STATUS_EN
  logic [2:0] count;
  logic       empty;
  logic       full;
`endif

  int errors = 0;
  int checks = 0;

  int         m_idx = 3;
  int         m_cnt = 0;
  logic [7:0] m_mem [4];

  always #5 clk = ~clk;

  stack #(.StackDepth(4), .DataWidth(8)) dut (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .data_in(data_in),
    .data_out(data_out),
`ifdef STACK_STATUS_EN
    .count(count),
    .empty(empty),
    .full(full),
`endif
    .index_out(index_out)
  );

  // Drive one cycle and advance the reference model by the stack rules.
  task automatic step(input logic p, input logic q,
                      input logic [7:0] d, input logic r);
    push = p;
    pop = q;
    data_in = d;
    reset = r;
    @(posedge clk);
    if (!r) begin
      m_idx = 3;
      m_cnt = 0;
      for (int i = 0; i < 4; i++) m_mem[i] = '0;
    end else if (p && !q) begin
      m_idx = (m_idx + 3) % 4;
      m_mem[m_idx] = d;
      if (m_cnt < 4) m_cnt++;
    end else if (q && !p) begin
      m_idx = (m_idx + 1) % 4;
      if (m_cnt > 0) m_cnt--;
    end else if (p && q) begin
      m_mem[m_idx] = d;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (index_out !== 2'd3 || data_out !== 8'd0) begin
      errors++;
      $display("FAIL reset: got idx=%0d data=%0d, want idx=3 data=0",
               index_out, data_out);
    end
  endtask

  task automatic test_push_idle();
    step(1'b1, 1'b0, 8'd1, 1'b1);
    checks++;
    if (index_out !== 2'd2 || data_out !== 8'd1) begin
      errors++;
      $display("FAIL push1: got idx=%0d data=%0d, want idx=2 data=1",
               index_out, data_out);
    end
    step(1'b0, 1'b0, 8'd77, 1'b1);
    checks++;
    if (index_out !== 2'd2 || data_out !== 8'd1) begin
      errors++;
      $display("FAIL idle: got idx=%0d data=%0d, want idx=2 data=1",
               index_out, data_out);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] ei [3] = '{2'd1, 2'd0, 2'd3};
    logic [7:0] ed [3] = '{8'd2, 8'd3, 8'd4};
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 8'(k + 2), 1'b1);
      checks++;
      if (index_out !== ei[k] || data_out !== ed[k]) begin
        errors++;
        $display("FAIL wrap%0d: got idx=%0d data=%0d, want idx=%0d data=%0d",
                 k, index_out, data_out, ei[k], ed[k]);
      end
    end
    step(1'b0, 1'b0, 8'd0, 1'b1);
    checks++;
    if (index_out !== 2'd3 || data_out !== 8'd4) begin
      errors++;
      $display("FAIL wrap_idle: got idx=%0d data=%0d, want idx=3 data=4",
               index_out, data_out);
    end
  endtask

  task automatic test_pop();
    logic [1:0] ei [3] = '{2'd0, 2'd1, 2'd2};
    logic [7:0] ed [3] = '{8'd3, 8'd2, 8'd1};
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 8'hFF, 1'b1);
      checks++;
      if (index_out !== ei[k] || data_out !== ed[k]) begin
        errors++;
        $display("FAIL pop%0d: got idx=%0d data=%0d, want idx=%0d data=%0d",
                 k, index_out, data_out, ei[k], ed[k]);
      end
    end
  endtask

  task automatic test_push_pop();
    step(1'b1, 1'b1, 8'd9, 1'b1);
    checks++;
    if (index_out !== 2'd2 || data_out !== 8'd9) begin
      errors++;
      $display("FAIL push_pop: got idx=%0d data=%0d, want idx=2 data=9",
               index_out, data_out);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 8'd5, 1'b0);
    checks++;
    if (index_out !== 2'd3 || data_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_pp: got idx=%0d data=%0d, want idx=3 data=0",
               index_out, data_out);
    end
    step(1'b1, 1'b0, 8'd6, 1'b1);
    step(1'b1, 1'b0, 8'd7, 1'b0);
    checks++;
    if (index_out !== 2'd3 || data_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_push: got idx=%0d data=%0d, want idx=3 data=0",
               index_out, data_out);
    end
    step(1'b0, 1'b0, 8'd0, 1'b1);
  endtask

`ifdef STACK_STATUS_EN
  task automatic test_status();
    step(1'b0, 1'b0, 8'd0, 1'b0);
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL st_reset: got cnt=%0d e=%b f=%b, want cnt=0 e=1 f=0",
               count, empty, full);
    end
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'(k + 20), 1'b1);
    checks++;
    if (full !== 1'b1 || empty !== 1'b0 || count !== 3'd4) begin
      errors++;
      $display("FAIL st_full: got cnt=%0d e=%b f=%b, want cnt=4 e=0 f=1",
               count, empty, full);
    end
    step(1'b1, 1'b0, 8'd30, 1'b1);
    checks++;
    if (full !== 1'b1 || count !== 3'd4 || index_out !== 2'd2) begin
      errors++;
      $display("FAIL st_sat: got cnt=%0d f=%b idx=%0d, want cnt=4 f=1 idx=2",
               count, full, index_out);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 8'd0, 1'b1);
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL st_empty: got cnt=%0d e=%b f=%b, want cnt=0 e=1 f=0",
               count, empty, full);
    end
    step(1'b0, 1'b1, 8'd0, 1'b1);
    checks++;
    if (count !== 3'd0 || index_out !== 2'd3) begin
      errors++;
      $display("FAIL st_under: got cnt=%0d idx=%0d, want cnt=0 idx=3",
               count, index_out);
    end
  endtask
`endif

  task automatic test_random();
    logic p, q, r;
    for (int n = 0; n < 300; n++) begin
      p = 1'($urandom_range(0, 1));
      q = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 39) != 0);
      step(p, q, 8'($urandom), r);
      checks++;
      if (index_out !== 2'(m_idx) || data_out !== m_mem[m_idx]) begin
        errors++;
        $display("FAIL rand%0d: got idx=%0d data=%0d, want idx=%0d data=%0d",
                 n, index_out, data_out, m_idx, m_mem[m_idx]);
      end
`ifdef STACK_STATUS_EN
      checks++;
      if (count !== 3'(m_cnt) || empty !== (m_cnt == 0) ||
          full !== (m_cnt == 4)) begin
        errors++;
        $display("FAIL rand_st%0d: got cnt=%0d e=%b f=%b, want cnt=%0d",
                 n, count, empty, full, m_cnt);
      end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_mem[i] = '0;
    test_reset();
    test_push_idle();
    test_wrap();
    test_pop();
    test_push_pop();
    test_reset_mid();
`ifdef STACK_STATUS_EN
    test_status();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack.md
Name: stack

Overview:
- Small circular register-file LIFO stack with a downward-growing index.
- Push writes the entry below the current top; pop moves the index back up.
- The top-of-stack entry and the index are always visible combinationally.
- Used in the core wherever nested context (e.g. interrupt or return state) must be saved and restored with zero-latency top access.

Parameters:
- StackDepth, 4, number of entries; must be a power of two and at least 2.
- DataWidth, 32, width of each entry in bits.
- StackDepthWidth, $clog2(StackDepth), derived index width; not to be overridden.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- push  input  1  push data_in this cycle.
- pop  input  1  pop the top entry this cycle.
- data_in  input  DataWidth  data to push.
- data_out  output  DataWidth  current top entry, mem[index], combinational read.
- index_out  output  StackDepthWidth  current top index.

Behaviour:
- Storage: mem[0..StackDepth-1] of DataWidth bits, plus an index register of StackDepthWidth bits.
- All state updates occur on the rising clk edge; outputs reflect new state after the edge (1-cycle latency).
- Reset (reset==0 at the clk edge):
  - index <= StackDepth-1; all mem entries <= 0.
  - Reset overrides push/pop and takes effect mid-operation with no partial update.
  - After reset: index_out=StackDepth-1, data_out=0.
- Push only (push=1, pop=0): index <= index-1 (modulo StackDepth); mem[index-1] <= data_in.
- Pop only (pop=1, push=0): index <= index+1 (modulo StackDepth); no memory write. The popped entry keeps its value.
- Push and pop together: mem[index] <= data_in (top replaced); index unchanged.
- Neither asserted: state held.
- Wrap-around:
  - Push from index 0 goes to StackDepth-1 and overwrites the oldest entry (no overflow error).
  - Pop from StackDepth-1 goes to 0 (no underflow error).
  - No stall or handshake; every request is accepted every cycle.
- data_out = mem[index] combinationally. A write to mem at the same edge is visible only after the edge.
- Index arithmetic is pure StackDepthWidth-bit modular add/sub.

Optional Feature:
- Macro STACK_STATUS_EN.
- Defined: adds three outputs, all reset with the stack, updated on the same edge as index, and behaving consistently with the wrap rules below.
  - count (StackDepthWidth+1 bits): occupancy 0..StackDepth.
    - Push-only increments count, saturating at StackDepth.
    - Pop-only decrements count, saturating at 0.
    - Push+pop together, or neither: unchanged.
  - empty = (count==0).
  - full = (count==StackDepth).
  - Index and memory behaviour, including wrap and overwrite, is unchanged.
- Not defined: the ports and counter logic are absent; the block has only the ports listed above.

Test Plan (StackDepth=4, DataWidth=8):
- Hold reset=0 for one edge, then reset=1 with push=pop=0 -> index_out=3, data_out=0.
- Push 1 -> index_out=2, data_out=1. Then idle one cycle -> unchanged (2, 1).
- Push 2, 3, 4 on consecutive cycles -> (1,2), (0,3), then wrap to (3,4) with the reset-zero entry at mem[3] overwritten. Then idle -> (3,4).
- Pop three times from (3,4) -> (0,3), (1,2), (2,1).
- Push+pop together with data_in=9 at index 2 -> index_out=2, data_out=9. Assert reset=0 mid-sequence -> next edge (3,0) regardless of push/pop.
- With STACK_STATUS_EN:
  - After reset: empty=1, count=0.
  - After 4 pushes: full=1, count=4; a 5th push keeps count=4.
  - After 4 pops: empty=1.
